// File: rtl/thermo_meter_pkg.sv
// rtl/thermo_meter_pkg.sv - shared types and decode helpers for the thermometer bar meter
package thermo_meter_pkg;

    typedef enum logic [1:0] {
        TRACK,
        HOLD,
        DECAY
    } peak_state_t;

    localparam int MAX_N  = 128;
    localparam int MAX_GW = 32;

    // Bar level: full groups below sel plus the position of the highest set fine bit.
    function automatic int level_calc(int groups, int group_w, int sel,
                                      logic [MAX_GW-1:0] fine);
        int                hi;
        logic [MAX_GW-1:0] f;
        hi = 0;
        f  = fine;
        if (sel >= groups) begin
            return groups * group_w;
        end
        for (int i = 0; i < MAX_GW; i++) begin
            if (i < group_w && f[0]) begin
                hi = i + 1;
            end
            f = f >> 1;
        end
        return sel * group_w + hi;
    endfunction

    // Built MSB-first by shifting so no bit select needs a variable index.
    function automatic logic [MAX_N-1:0] bar_decode(int groups, int group_w, int sel,
                                                    logic [MAX_GW-1:0] fine);
        logic [MAX_N-1:0]  r;
        logic [MAX_GW-1:0] f;
        int                g;
        r = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            g = i / group_w;
            f = fine >> (i % group_w);
            r = r << 1;
            if (i < groups * group_w) begin
                if (sel >= groups || g < sel) begin
                    r[0] = 1'b1;
                end else if (g == sel) begin
                    r[0] = f[0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/thermo_peak_tracker.sv
// rtl/thermo_peak_tracker.sv - peak-hold marker with timed hold and stepwise decay
module thermo_peak_tracker
    import thermo_meter_pkg::*;
#(
    parameter int N            = 16,
    parameter int LVL_W        = 5,
    parameter int HOLD_CYCLES  = 1024,
    parameter int DECAY_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic [LVL_W-1:0] sample_level,
    input  logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] peak_level,
    output logic [N-1:0]     peak_out
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int DW = $clog2(DECAY_CYCLES + 1);

    peak_state_t      state;
    logic [HW-1:0]    hold_cnt;
    logic [DW-1:0]    decay_cnt;
    logic [LVL_W-1:0] eff_level;
    logic             new_peak;
    logic             reach_level;

    function automatic logic [N-1:0] onehot(logic [LVL_W-1:0] p);
        if (p == '0) begin
            return '0;
        end
        return {{(N-1){1'b0}}, 1'b1} << (p - 1'b1);
    endfunction

    // Level that LEVEL will hold after this edge; decay must never go below it.
    assign eff_level   = sample_valid ? sample_level : level;
    assign new_peak    = sample_valid && (sample_level > peak_level);
    assign reach_level = ({1'b0, peak_level}) <= ({1'b0, eff_level} + (LVL_W+1)'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= TRACK;
            hold_cnt   <= '0;
            decay_cnt  <= '0;
            peak_level <= '0;
            peak_out   <= '0;
        end else if (new_peak) begin
            state      <= HOLD;
            hold_cnt   <= HW'(HOLD_CYCLES - 1);
            peak_level <= sample_level;
            peak_out   <= onehot(sample_level);
        end else begin
            case (state)
                HOLD: begin
                    if (hold_cnt == '0) begin
                        decay_cnt <= DW'(DECAY_CYCLES - 1);
                        state     <= DECAY;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                DECAY: begin
                    if (decay_cnt != '0) begin
                        decay_cnt <= decay_cnt - 1'b1;
                    end else if (reach_level) begin
                        peak_level <= eff_level;
                        peak_out   <= onehot(eff_level);
                        state      <= TRACK;
                    end else begin
                        peak_level <= peak_level - 1'b1;
                        peak_out   <= onehot(peak_level - 1'b1);
                        decay_cnt  <= DW'(DECAY_CYCLES - 1);
                    end
                end
                default: begin
                    state <= TRACK;
                end
            endcase
        end
    end

endmodule

// File: rtl/thermo_bar_meter.sv
// rtl/thermo_bar_meter.sv - registered group/fine thermometer bar decoder; peak hold under THERMO_PEAK_HOLD_EN
module thermo_bar_meter
    import thermo_meter_pkg::*;
#(
    parameter int GROUPS       = 4,
    parameter int GROUP_W      = 4,
    parameter int HOLD_CYCLES  = 1024,
    parameter int DECAY_CYCLES = 64,
    localparam int SEL_W       = $clog2(GROUPS),
    localparam int N           = GROUPS * GROUP_W,
    localparam int LVL_W       = $clog2(N + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W+GROUP_W-1:0] in,
    input  logic                     in_valid,
    output logic [N-1:0]             out,
    output logic [LVL_W-1:0]         level,
    output logic [LVL_W-1:0]         peak_level,
    output logic [N-1:0]             peak_out
);

    logic [SEL_W-1:0]   sel;
    logic [GROUP_W-1:0] fine;
    logic [N-1:0]       sample_bar;
    logic [LVL_W-1:0]   sample_level;

    assign sel  = in[SEL_W+GROUP_W-1:GROUP_W];
    assign fine = in[GROUP_W-1:0];

    always_comb begin
        sample_bar   = N'(bar_decode(GROUPS, GROUP_W, int'(sel), MAX_GW'(fine)));
        sample_level = LVL_W'(level_calc(GROUPS, GROUP_W, int'(sel), MAX_GW'(fine)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out   <= '0;
            level <= '0;
        end else if (in_valid) begin
            out   <= sample_bar;
            level <= sample_level;
        end
    end

`ifdef THERMO_PEAK_HOLD_EN
    thermo_peak_tracker #(
        .N            (N),
        .LVL_W        (LVL_W),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .DECAY_CYCLES (DECAY_CYCLES)
    ) u_peak (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (in_valid),
        .sample_level (sample_level),
        .level        (level),
        .peak_level   (peak_level),
        .peak_out     (peak_out)
    );
`else
    assign peak_level = '0;
    assign peak_out   = '0;
`endif

endmodule

// File: tb/tb_thermo_bar_meter.sv
// tb/tb_thermo_bar_meter.sv - scoreboard bench for thermo_bar_meter against a behavioural model
module tb_thermo_bar_meter;

    localparam int GROUPS  = 4;
    localparam int GROUP_W = 4;
    localparam int HC      = 8;
    localparam int DC      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in = '0;
    logic [15:0] out;
    logic [4:0]  level;
    logic [4:0]  peak_level;
    logic [15:0] peak_out;

    thermo_bar_meter #(
        .GROUPS       (GROUPS),
        .GROUP_W      (GROUP_W),
        .HOLD_CYCLES  (HC),
        .DECAY_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .out        (out),
        .level      (level),
        .peak_level (peak_level),
        .peak_out   (peak_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_out;
        int e_level;
        int e_peak;
        int e_peak_out;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_out = 0, m_level = 0, m_peak = 0, m_active = 0, m_next = 0;

    function automatic int ref_level(logic [5:0] x);
        int sel = int'(x[5:4]);
        int hi  = 0;
        for (int b = 0; b < 4; b++) begin
            if (((int'(x[3:0]) >> b) & 1) == 1) hi = b + 1;
        end
        return sel * 4 + hi;
    endfunction

    function automatic int ref_out(logic [5:0] x);
        int sel = int'(x[5:4]);
        return (((1 << (sel * 4)) - 1) | (int'(x[3:0]) << (sel * 4))) & 32'hFFFF;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, advance the model, queue what the next rising edge must show.
    task automatic cycle(bit r, bit v, logic [5:0] x);
        exp_t e;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in       = x;
        if (!r) begin
            m_out = 0; m_level = 0; m_peak = 0; m_active = 0; m_next = 0;
        end else begin
            if (v) begin
                m_out   = ref_out(x);
                m_level = ref_level(x);
            end
            if (v && m_level > m_peak) begin
                m_peak   = m_level;
                m_active = 1;
                m_next   = HC + DC;
            end else if (m_active == 1) begin
                m_next--;
                if (m_next == 0) begin
                    if (m_peak - 1 <= m_level) begin
                        m_peak   = m_level;
                        m_active = 0;
                    end else begin
                        m_peak--;
                        m_next = DC;
                    end
                end
            end
        end
        e.e_out   = m_out;
        e.e_level = m_level;
`ifdef THERMO_PEAK_HOLD_EN
        e.e_peak     = m_peak;
        e.e_peak_out = (m_peak == 0) ? 0 : (1 << (m_peak - 1));
`else
        e.e_peak     = 0;
        e.e_peak_out = 0;
`endif
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out", int'(out), e.e_out);
                chk("level", int'(level), e.e_level);
                chk("peak_level", int'(peak_level), e.e_peak);
                chk("peak_out", int'(peak_out), e.e_peak_out);
            end
        end
    end

    task automatic bound_fail(string name, int act, int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (wait bound expired)", name, act, exp);
    endtask

    initial begin
        int k;
        cycle(0, 0, 6'h00);
        cycle(0, 0, 6'h00);
        cycle(1, 1, 6'b01_0101);
        cycle(1, 1, 6'b11_1000);
        repeat (40) cycle(1, 1, 6'b00_0001);

        // Re-peak while decaying through 12.
        cycle(1, 1, 6'b11_1000);
        for (k = 0; k < 100 && m_peak != 12; k++) cycle(1, 1, 6'b00_0001);
        if (m_peak != 12) bound_fail("peak_wait12", m_peak, 12);
        cycle(1, 1, 6'b11_0100);
        repeat (14) cycle(1, 1, 6'b00_0001);

        repeat (5) cycle(1, 0, 6'($urandom));

        // Reset in the middle of a decay.
        cycle(1, 1, 6'b11_1111);
        for (k = 0; k < 100 && !(m_active == 1 && m_peak < 16); k++) cycle(1, 1, 6'b00_0000);
        if (m_peak >= 16) bound_fail("decay_wait", m_peak, 15);
        cycle(0, 1, 6'($urandom));
        cycle(1, 0, 6'b11_1111);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  (i % 50 < 10) ? 6'($urandom) : 6'($urandom_range(0, 20)));
        end

        for (k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        if (sb.size() > 0) bound_fail("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
